// File: rtl/agu_pipe_stage.sv
// Address-generation stage: operand bypass, four address modes, misalign
// detection and counting, and a 2-entry skid buffer between ID and MEM.
module agu_pipe_stage #(
    parameter int WIDTH   = 32,
    parameter int NUM_FWD = 2,
    parameter int TAG_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clkEn,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_r1,
    input  logic [WIDTH-1:0]         in_r2,
    input  logic [WIDTH-1:0]         in_imm,
    input  logic [1:0]               in_mode,
    input  logic [1:0]               in_size,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]       fwd_hit1,
    input  logic [NUM_FWD-1:0]       fwd_hit2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_addr,
    output logic [1:0]               out_size,
    output logic                     out_misalign,
    output logic [TAG_W-1:0]         out_tag,
    output logic [15:0]              misalign_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [1:0]       size;
        logic             mis;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t        main_q, main_d, skid_q, skid_d, new_ent;
    logic        mv_q, mv_d, sv_q, sv_d;
    logic [15:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op1, op2, addr;
    logic        mis, push, pop;

    // Walk channels high to low so the lowest-index hit is the last to win.
    always_comb begin
        op1 = in_r1;
        op2 = in_r2;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_hit1[k]) op1 = fwd_data[k*WIDTH +: WIDTH];
            if (fwd_hit2[k]) op2 = fwd_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        case (in_mode)
            2'd0:    addr = op1 + op2;
            2'd1:    addr = op1 + in_imm;
            2'd2:    addr = in_pc + in_imm;
            default: addr = in_imm;
        endcase
        case (in_size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr[0];
            2'd2:    mis = |addr[1:0];
            default: mis = |addr[2:0];
        endcase
        new_ent = '{addr: addr, size: in_size, mis: mis, tag: in_tag};
    end

    assign in_ready  = clkEn & ~sv_q;
    assign out_valid = clkEn & mv_q;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        mv_d   = mv_q;
        sv_d   = sv_q;
        cnt_d  = cnt_q;
        if (clkEn) begin
            if (flush) begin
                mv_d = 1'b0;
                sv_d = 1'b0;
            end else begin
                if (pop) begin
                    if (sv_q) begin
                        main_d = skid_q;
                        sv_d   = 1'b0;
                    end else if (push) begin
                        main_d = new_ent;
                    end else begin
                        mv_d = 1'b0;
                    end
                end else if (push) begin
                    if (mv_q) begin
                        skid_d = new_ent;
                        sv_d   = 1'b1;
                    end else begin
                        main_d = new_ent;
                        mv_d   = 1'b1;
                    end
                end
                if (push && mis && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
            mv_q   <= 1'b0;
            sv_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            mv_q   <= mv_d;
            sv_q   <= sv_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out_addr     = main_q.addr;
    assign out_size     = main_q.size;
    assign out_misalign = main_q.mis;
    assign out_tag      = main_q.tag;
    assign misalign_cnt = cnt_q;

endmodule

// File: tb/tb_agu_pipe_stage.sv
// Directed bench for agu_pipe_stage with three forwarding channels.
module tb_agu_pipe_stage;

    localparam int W = 32;
    localparam int NF = 3;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic rst, clkEn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_pc, in_r1, in_r2, in_imm, out_addr;
    logic [1:0] in_mode, in_size, out_size;
    logic [TW-1:0] in_tag, out_tag;
    logic [NF*W-1:0] fwd_data;
    logic [NF-1:0] fwd_hit1, fwd_hit2;
    logic out_misalign;
    logic [15:0] misalign_cnt;

    int tests = 0;
    int fails = 0;

    agu_pipe_stage #(.WIDTH(W), .NUM_FWD(NF), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .clkEn(clkEn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_r1(in_r1), .in_r2(in_r2), .in_imm(in_imm),
        .in_mode(in_mode), .in_size(in_size), .in_tag(in_tag),
        .fwd_data(fwd_data), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_size(out_size),
        .out_misalign(out_misalign), .out_tag(out_tag),
        .misalign_cnt(misalign_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] mode, input logic [1:0] size,
                      input logic [31:0] imm, input logic [15:0] tag);
        in_valid = 1'b1;
        in_mode  = mode;
        in_size  = size;
        in_imm   = imm;
        in_tag   = tag;
    endtask

    initial begin
        rst = 1'b1; clkEn = 1'b1; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        in_pc = 32'h400; in_r1 = 32'h1000; in_r2 = 32'h24;
        in_imm = 32'hFFFF_FFFC; in_mode = 2'd0; in_size = 2'd2; in_tag = '0;
        fwd_data = '0; fwd_hit1 = '0; fwd_hit2 = '0;
        tick;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_addr", out_addr, 32'd0);
        chk("rst_tag", {16'b0, out_tag}, 32'd0);
        chk("rst_cnt", {16'b0, misalign_cnt}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Address modes, streaming one op per cycle
        op(2'd0, 2'd2, 32'hFFFF_FFFC, 16'h10);
        tick;
        chk("m0_valid", {31'b0, out_valid}, 32'd1);
        chk("m0_addr", out_addr, 32'h1024);
        chk("m0_mis", {31'b0, out_misalign}, 32'd0);
        chk("m0_size", {30'b0, out_size}, 32'd2);
        chk("m0_tag", {16'b0, out_tag}, 32'h10);
        op(2'd1, 2'd2, 32'hFFFF_FFFC, 16'h11);
        tick;
        chk("m1_addr", out_addr, 32'hFFC);
        chk("m1_mis", {31'b0, out_misalign}, 32'd0);
        op(2'd2, 2'd2, 32'hFFFF_FFFC, 16'h12);
        tick;
        chk("m2_addr", out_addr, 32'h3FC);
        chk("m2_tag", {16'b0, out_tag}, 32'h12);
        op(2'd3, 2'd2, 32'hFFFF_FFFC, 16'h13);
        tick;
        chk("m3_addr", out_addr, 32'hFFFF_FFFC);
        chk("m3_mis", {31'b0, out_misalign}, 32'd0);
        in_valid = 1'b0;
        tick;
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Forwarding: lowest-index hit wins
        fwd_data = {32'h300, 32'h200, 32'h10};
        fwd_hit1 = 3'b110;
        in_r1 = 32'h5;
        op(2'd1, 2'd2, 32'h4, 16'h20);
        tick;
        chk("fwd1_addr", out_addr, 32'h204);
        fwd_hit1 = 3'b000;
        fwd_hit2 = 3'b111;
        in_r1 = 32'h1000;
        op(2'd0, 2'd0, 32'h4, 16'h21);
        tick;
        chk("fwd2_addr", out_addr, 32'h1010);
        fwd_hit2 = 3'b100;
        op(2'd2, 2'd0, 32'h8, 16'h22);
        tick;
        chk("fwd_pc_addr", out_addr, 32'h408);
        in_valid = 1'b0;
        fwd_hit2 = '0;
        tick;

        // Back-pressure through the skid entry
        out_ready = 1'b0;
        op(2'd3, 2'd2, 32'h100, 16'd1);
        tick;
        chk("bp_a_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_a_ready", {31'b0, in_ready}, 32'd1);
        op(2'd3, 2'd2, 32'h104, 16'd2);
        tick;
        chk("bp_b_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_b_head", {16'b0, out_tag}, 32'd1);
        op(2'd3, 2'd2, 32'h108, 16'd3);
        tick;
        chk("bp_c_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_c_head", {16'b0, out_tag}, 32'd1);
        out_ready = 1'b1;
        tick;
        chk("bp_pop1_tag", {16'b0, out_tag}, 32'd2);
        chk("bp_pop1_addr", out_addr, 32'h104);
        chk("bp_pop1_ready", {31'b0, in_ready}, 32'd1);
        tick;
        chk("bp_pop2_tag", {16'b0, out_tag}, 32'd3);
        chk("bp_pop2_addr", out_addr, 32'h108);
        in_valid = 1'b0;
        tick;
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush with two ops buffered
        out_ready = 1'b0;
        op(2'd3, 2'd1, 32'h201, 16'd4);
        tick;
        op(2'd3, 2'd1, 32'h203, 16'd5);
        tick;
        chk("fl_full", {31'b0, in_ready}, 32'd0);
        chk("fl_cnt_pre", {16'b0, misalign_cnt}, 32'd2);
        flush = 1'b1;
        op(2'd3, 2'd1, 32'h205, 16'd6);
        tick;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        tick;
        chk("fl_accept_cancel", {31'b0, out_valid}, 32'd0);
        chk("fl_cnt_kept", {16'b0, misalign_cnt}, 32'd2);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;

        // Misalign detection and counter saturation
        op(2'd3, 2'd1, 32'h1001, 16'd7);
        tick;
        chk("mis_h", {31'b0, out_misalign}, 32'd1);
        chk("mis_cnt3", {16'b0, misalign_cnt}, 32'd3);
        op(2'd3, 2'd3, 32'h1004, 16'd8);
        tick;
        chk("mis_d", {31'b0, out_misalign}, 32'd1);
        op(2'd3, 2'd0, 32'h1001, 16'd9);
        tick;
        chk("mis_b", {31'b0, out_misalign}, 32'd0);
        chk("mis_cnt4", {16'b0, misalign_cnt}, 32'd4);
        op(2'd3, 2'd2, 32'h1004, 16'd10);
        tick;
        chk("mis_w_ok", {31'b0, out_misalign}, 32'd0);
        op(2'd3, 2'd1, 32'h1001, 16'd11);
        for (int i = 0; i < 65531; i++) tick;
        chk("sat_reach", {16'b0, misalign_cnt}, 32'hFFFF);
        tick;
        chk("sat_hold", {16'b0, misalign_cnt}, 32'hFFFF);
        in_valid = 1'b0;
        tick;

        // Async reset mid-cycle with skid full
        out_ready = 1'b0;
        op(2'd3, 2'd1, 32'h301, 16'd12);
        tick;
        op(2'd3, 2'd1, 32'h303, 16'd13);
        tick;
        in_valid = 1'b0;
        chk("ar_pre_ready", {31'b0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_cnt", {16'b0, misalign_cnt}, 32'd0);
        chk("ar_addr", out_addr, 32'd0);
        tick;
        rst = 1'b0;

        // Clock-enable freeze
        clkEn = 1'b0;
        out_ready = 1'b1;
        op(2'd3, 2'd2, 32'h500, 16'd14);
        #1;
        chk("ce_in_ready", {31'b0, in_ready}, 32'd0);
        tick;
        tick;
        chk("ce_no_xfer", {31'b0, out_valid}, 32'd0);
        clkEn = 1'b1;
        #1;
        chk("ce_still_empty", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        clkEn = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        clkEn = 1'b1;
        #1;
        chk("ce_held_valid", {31'b0, out_valid}, 32'd1);
        chk("ce_held_tag", {16'b0, out_tag}, 32'd14);
        tick;
        chk("ce_final_pop", {31'b0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
